// File: rtl/dice_pkg.sv
// -----------------------------------------------------------------------------
// dice_pkg -- shared definitions for the dice roller.
//   state_e        : controller states
//   LFSR_SEED/TAPS : 16-bit Fibonacci LFSR seed and feedback mask
//   PIP_FACE1..6   : face-to-pip table (bit 0 = pip a ... bit 6 = pip g)
//   face_to_pips() : table lookup, unreachable faces give all pips off
//   lfsr_next()    : one LFSR shift
//   face_advance() : move a face forward by k = r + 1 with 6 -> 1 wrap
// -----------------------------------------------------------------------------
package dice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROLLING  = 2'd1,
    ST_SETTLING = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic [2:0] FACE_RESET = 3'd1;

  // Pip layout: a=top-left b=top-right c=mid-left d=centre e=mid-right
  //             f=bottom-left g=bottom-right
  localparam logic [6:0] PIP_NONE  = 7'b0000000;
  localparam logic [6:0] PIP_FACE1 = 7'b0001000;
  localparam logic [6:0] PIP_FACE2 = 7'b1000001;
  localparam logic [6:0] PIP_FACE3 = 7'b1001001;
  localparam logic [6:0] PIP_FACE4 = 7'b1100011;
  localparam logic [6:0] PIP_FACE5 = 7'b1101011;
  localparam logic [6:0] PIP_FACE6 = 7'b1110111;

  function automatic logic [6:0] face_to_pips(input logic [2:0] face);
    logic [6:0] pips;
    case (face)
      3'd1:    pips = PIP_FACE1;
      3'd2:    pips = PIP_FACE2;
      3'd3:    pips = PIP_FACE3;
      3'd4:    pips = PIP_FACE4;
      3'd5:    pips = PIP_FACE5;
      3'd6:    pips = PIP_FACE6;
      default: pips = PIP_NONE;
    endcase
    return pips;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] lfsr);
    return {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  endfunction

  // face' = ((face - 1 + k) mod 6) + 1 with k = r + 1, i.e. ((face + r) mod 6) + 1.
  // For legal faces face + r lies in 1..9, so a single conditional subtract suffices.
  function automatic logic [2:0] face_advance(input logic [2:0] face, input logic [1:0] r);
    logic [3:0] sum;
    logic [2:0] res;
    sum = {1'b0, face} + {2'b00, r};
    if (sum >= 4'd6) begin
      res = 3'(sum - 4'd5);
    end else begin
      res = 3'(sum + 4'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/dice_roller_if.sv
// -----------------------------------------------------------------------------
// dice_roller_if -- request/result bundle of the dice roller.
//   roll  : level request, high = keep rolling
//   face  : 3 bits per die, die i in [3i+2:3i]
//   pips  : 7 bits per die, die i in [7i+6:7i]
//   busy  : rolling or settling
//   valid : one-cycle pulse when the final faces are stable
// master = requester side, slave = dice_roller side.
// -----------------------------------------------------------------------------
interface dice_roller_if #(
  parameter int N_DICE = 2
);
  logic                  roll;
  logic [3*N_DICE-1:0]   face;
  logic [7*N_DICE-1:0]   pips;
  logic                  busy;
  logic                  valid;

  modport master (output roll, input face, pips, busy, valid);
  modport slave  (input roll, output face, pips, busy, valid);
endinterface

// File: rtl/dice_pip_decode.sv
// -----------------------------------------------------------------------------
// dice_pip_decode -- combinational face to pip-pattern decode for one die.
//   face : 3-bit face value (1..6; 0 and 7 decode to all off)
//   pips : 7-bit pattern, bit 0 = pip a ... bit 6 = pip g
// -----------------------------------------------------------------------------
module dice_pip_decode
  import dice_pkg::*;
(
  input  logic [2:0] face,
  output logic [6:0] pips
);

  // Table lookup from the shared package
  always_comb begin
    pips = face_to_pips(face);
  end

endmodule

// File: rtl/dice_roller.sv
// -----------------------------------------------------------------------------
// dice_roller -- N_DICE electronic dice sharing one LFSR, one step counter
// and one controller. While roll is high the dice step every ROLL_DIV cycles;
// after release they take SETTLE_STEPS steps at doubling intervals, then
// valid pulses for one cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dice_roller_if slave (roll in; face, pips, busy, valid out)
// -----------------------------------------------------------------------------
module dice_roller
  import dice_pkg::*;
#(
  parameter int N_DICE       = 2,
  parameter int ROLL_DIV     = 4,
  parameter int SETTLE_STEPS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  dice_roller_if.slave bus
);

  // Wide enough for the longest settle interval minus one
  localparam int CNT_W = $clog2(ROLL_DIV << SETTLE_STEPS) + 1;

  state_e              state_r;
  state_e              state_nx_s;
  logic [15:0]         lfsr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nx_s;
  logic [CNT_W-1:0]    limit_s;
  logic [2:0]          j_r;
  logic [2:0]          j_nx_s;
  logic                step_s;
  logic [3*N_DICE-1:0] face_r;
  logic [3*N_DICE-1:0] face_step_s;
  logic [7*N_DICE-1:0] pips_s;
  logic                busy_s;
  logic                valid_s;

  // Terminal count of the current step interval (ROLL_DIV, or ROLL_DIV*2^j when settling)
  always_comb begin
    if (state_r == ST_SETTLING) begin
      limit_s = (CNT_W'(ROLL_DIV) << j_r) - CNT_W'(1);
    end else begin
      limit_s = CNT_W'(ROLL_DIV) - CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.roll) state_nx_s = ST_ROLLING;
        else          state_nx_s = ST_IDLE;
      end
      ST_ROLLING: begin
        if (!bus.roll) state_nx_s = ST_SETTLING;
        else           state_nx_s = ST_ROLLING;
      end
      ST_SETTLING: begin
        if (bus.roll) begin
          state_nx_s = ST_ROLLING;
        end else if ((cnt_r == limit_s) && (j_r == 3'(SETTLE_STEPS))) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SETTLING;
        end
      end
      ST_DONE: begin
        if (bus.roll) state_nx_s = ST_ROLLING;
        else          state_nx_s = ST_IDLE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Step strobe, interval counter and settle index
  always_comb begin
    step_s   = 1'b0;
    cnt_nx_s = cnt_r;
    j_nx_s   = j_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nx_s = '0;
        j_nx_s   = 3'd0;
      end
      ST_ROLLING: begin
        // A due step still happens in the cycle roll drops
        if (cnt_r == limit_s) begin
          step_s   = 1'b1;
          cnt_nx_s = '0;
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
        if (!bus.roll) begin
          cnt_nx_s = '0;
          j_nx_s   = 3'd1;
        end else begin
          j_nx_s   = 3'd0;
        end
      end
      ST_SETTLING: begin
        if (bus.roll) begin
          // Back to rolling: restart the interval, no step this cycle
          cnt_nx_s = '0;
          j_nx_s   = 3'd0;
        end else if (cnt_r == limit_s) begin
          step_s   = 1'b1;
          cnt_nx_s = '0;
          if (j_r == 3'(SETTLE_STEPS)) j_nx_s = 3'd0;
          else                         j_nx_s = j_r + 3'd1;
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        cnt_nx_s = '0;
        j_nx_s   = 3'd0;
      end
      default: begin
        cnt_nx_s = '0;
        j_nx_s   = 3'd0;
      end
    endcase
  end

  // Counter and settle index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      j_r   <= 3'd0;
    end else begin
      cnt_r <= cnt_nx_s;
      j_r   <= j_nx_s;
    end
  end

  // Free-running LFSR, advances in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Candidate next faces: die i uses LFSR slice [2i+1:2i]
  always_comb begin
    face_step_s = face_r;
    for (int i = 0; i < N_DICE; i++) begin
      face_step_s[3*i +: 3] = face_advance(face_r[3*i +: 3], lfsr_r[2*i +: 2]);
    end
  end

  // Per-die face registers, all dice move together on a step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      face_r <= {N_DICE{FACE_RESET}};
    end else if (step_s) begin
      face_r <= face_step_s;
    end else begin
      face_r <= face_r;
    end
  end

  for (genvar g = 0; g < N_DICE; g++) begin : g_pips
    dice_pip_decode u_pip_decode (
      .face (face_r[3*g +: 3]),
      .pips (pips_s[7*g +: 7])
    );
  end

  // Status decodes of the registered state
  always_comb begin
    busy_s  = 1'b0;
    valid_s = 1'b0;
    case (state_r)
      ST_ROLLING:  busy_s  = 1'b1;
      ST_SETTLING: busy_s  = 1'b1;
      ST_DONE:     valid_s = 1'b1;
      default: begin
        busy_s  = 1'b0;
        valid_s = 1'b0;
      end
    endcase
  end

  assign bus.face  = face_r;
  assign bus.pips  = pips_s;
  assign bus.busy  = busy_s;
  assign bus.valid = valid_s;

endmodule

// File: tb/tb_dice_roller.sv
// -----------------------------------------------------------------------------
// tb_dice_roller -- directed bench for dice_roller.
// dut_a: defaults (2 dice, ROLL_DIV 4, 3 settle steps).
// dut_b: 4 dice, ROLL_DIV 2, 6 settle steps.
// A stand-alone dice_pip_decode covers every face code.
// Monitors record the cycle of every face change and check each change
// against an independent LFSR / face model.
// -----------------------------------------------------------------------------
module tb_dice_roller;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  dice_roller_if #(.N_DICE(2)) bus_a ();
  dice_roller_if #(.N_DICE(4)) bus_b ();

  dice_roller #(.N_DICE(2), .ROLL_DIV(4), .SETTLE_STEPS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  dice_roller #(.N_DICE(4), .ROLL_DIV(2), .SETTLE_STEPS(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  logic [2:0] dec_face;
  logic [6:0] dec_pips;
  dice_pip_decode u_dec (.face(dec_face), .pips(dec_pips));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference LFSR: taps 16,14,13,11 in right-shift form
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  // One die forward by r+1 faces, counted pip by pip with wrap
  function automatic logic [2:0] ref_adv(input logic [2:0] f, input logic [1:0] r);
    logic [2:0] x;
    x = f;
    for (int s = 0; s <= int'(r); s++) x = (x == 3'd6) ? 3'd1 : x + 3'd1;
    return x;
  endfunction

  function automatic logic [11:0] ref_step(input logic [11:0] f, input logic [15:0] l, input int n);
    logic [11:0] o;
    o = f;
    for (int i = 0; i < n; i++) o[3*i +: 3] = ref_adv(f[3*i +: 3], l[2*i +: 2]);
    return o;
  endfunction

  int step_qa[$];
  int valid_qa[$];
  int step_qb[$];
  int valid_qb[$];
  int bad_step = 0;
  int range_bad = 0;
  int overlap = 0;
  logic [11:0] pa, pb;
  logic [15:0] pla, plb;

  // Monitor dut_a: face changes, range, valid, busy/valid overlap
  always @(negedge clk) begin
    if (!rst_n) begin
      pa  <= {6'd0, bus_a.face};
      pla <= m_lfsr;
    end else begin
      if ({6'd0, bus_a.face} != pa) begin
        step_qa.push_back(cyc);
        if ({6'd0, bus_a.face} !== ref_step(pa, pla, 2)) bad_step <= bad_step + 1;
      end
      pa  <= {6'd0, bus_a.face};
      pla <= m_lfsr;
      if (bus_a.face[2:0] == 3'd0 || bus_a.face[2:0] > 3'd6 ||
          bus_a.face[5:3] == 3'd0 || bus_a.face[5:3] > 3'd6) range_bad <= range_bad + 1;
      if (bus_a.valid) valid_qa.push_back(cyc);
      if (bus_a.valid && bus_a.busy) overlap <= overlap + 1;
    end
  end

  // Monitor dut_b
  always @(negedge clk) begin
    if (!rst_n) begin
      pb  <= bus_b.face;
      plb <= m_lfsr;
    end else begin
      if (bus_b.face != pb) begin
        step_qb.push_back(cyc);
        if (bus_b.face !== ref_step(pb, plb, 4)) bad_step <= bad_step + 1;
      end
      pb  <= bus_b.face;
      plb <= m_lfsr;
      if (bus_b.valid) valid_qb.push_back(cyc);
      if (bus_b.valid && bus_b.busy) overlap <= overlap + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_steps(input string tag, input int got[$], input int base, input int exp[$]);
    int g;
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? got[i] - base : -1;
      chk(tag, g, exp[i]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int busy_low;
  int valid_hi;
  task automatic run_watch(input int n);
    repeat (n) begin
      tick(1);
      if (!bus_a.busy) busy_low++;
      if (bus_a.valid) valid_hi++;
    end
  endtask

  logic [6:0] exp_pips [8];
  int mark;
  int exp_q[$];

  initial begin
    exp_pips[0] = 7'b0000000; exp_pips[1] = 7'b0001000;
    exp_pips[2] = 7'b1000001; exp_pips[3] = 7'b1001001;
    exp_pips[4] = 7'b1100011; exp_pips[5] = 7'b1101011;
    exp_pips[6] = 7'b1110111; exp_pips[7] = 7'b0000000;

    rst_n = 1'b0; bus_a.roll = 1'b0; bus_b.roll = 1'b0; dec_face = 3'd0;
    tick(2);
    chk("rst_face",  32'(bus_a.face), 32'h9);
    chk("rst_pips",  32'(bus_a.pips), 32'(14'b0001000_0001000));
    chk("rst_busy",  32'(bus_a.busy), 32'd0);
    chk("rst_valid", 32'(bus_a.valid), 32'd0);
    rst_n = 1'b1;

    // Idle for 20 cycles: nothing moves
    tick(20);
    chk("idle_face",   32'(bus_a.face), 32'h9);
    chk("idle_pips",   32'(bus_a.pips), 32'(14'b0001000_0001000));
    chk("idle_busy",   32'(bus_a.busy), 32'd0);
    chk("idle_valid",  32'(bus_a.valid), 32'd0);
    chk("idle_b_face", 32'(bus_b.face), 32'h249);
    chk("idle_steps",  32'(step_qa.size()), 32'd0);

    // Full decode sweep
    for (int f = 0; f < 8; f++) begin
      dec_face = 3'(f);
      #1;
      chk("decode", {25'd0, dec_pips}, {25'd0, exp_pips[f]});
    end

    // Roll 12 cycles then release: steps 4,8,12 after entry, then 8,16,32
    tick(1);
    step_qa.delete(); valid_qa.delete();
    mark = cyc; bus_a.roll = 1'b1;
    tick(1);
    chk("roll_busy", 32'(bus_a.busy), 32'd1);
    tick(11);
    bus_a.roll = 1'b0;
    tick(57);
    chk("done_valid", 32'(bus_a.valid), 32'd1);
    chk("done_busy",  32'(bus_a.busy), 32'd0);
    tick(1);
    chk("idle2_valid", 32'(bus_a.valid), 32'd0);
    chk("idle2_busy",  32'(bus_a.busy), 32'd0);
    exp_q = {5, 9, 13, 21, 37, 69};
    chk_steps("roll_steps", step_qa, mark, exp_q);
    chk("valid_count", 32'(valid_qa.size()), 32'd1);
    chk("valid_at", (valid_qa.size() > 0) ? 32'(valid_qa[0] - mark) : 32'hFFFF_FFFF, 32'd69);
    chk("model_a", 32'(bad_step), 32'd0);

    // Re-roll 5 cycles into settling, then reset mid-settle
    step_qa.delete(); valid_qa.delete(); busy_low = 0; valid_hi = 0;
    mark = cyc; bus_a.roll = 1'b1;
    run_watch(6);
    bus_a.roll = 1'b0;
    run_watch(5);
    bus_a.roll = 1'b1;
    run_watch(10);
    bus_a.roll = 1'b0;
    run_watch(5);
    chk("reroll_busy_low", 32'(busy_low), 32'd0);
    chk("reroll_valid",    32'(valid_hi), 32'd0);
    exp_q = {5, 16, 20};
    chk_steps("reroll_steps", step_qa, mark, exp_q);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_face",  32'(bus_a.face), 32'h9);
    chk("arst_pips",  32'(bus_a.pips), 32'(14'b0001000_0001000));
    chk("arst_busy",  32'(bus_a.busy), 32'd0);
    chk("arst_valid", 32'(bus_a.valid), 32'd0);
    tick(2);
    rst_n = 1'b1;
    step_qa.delete();
    tick(10);
    chk("post_rst_valid", 32'(valid_qa.size()), 32'd0);
    chk("post_rst_steps", 32'(step_qa.size()), 32'd0);
    chk("post_rst_busy",  32'(bus_a.busy), 32'd0);

    // Long random roll pattern
    step_qa.delete();
    for (int c = 0; c < 10000; c++) begin
      tick(1);
      if ($urandom_range(0, 15) == 0) bus_a.roll = ~bus_a.roll;
    end
    bus_a.roll = 1'b0;
    tick(200);
    chk("rand_range",   32'(range_bad), 32'd0);
    chk("rand_model",   32'(bad_step), 32'd0);
    chk("rand_moved",   32'(step_qa.size() != 0), 32'd1);
    chk("rand_idle",    32'(bus_a.busy), 32'd0);

    // dut_b: 4 dice, ROLL_DIV 2, six settle steps ending with a 128-cycle interval
    step_qb.delete(); valid_qb.delete();
    mark = cyc; bus_b.roll = 1'b1;
    tick(4);
    bus_b.roll = 1'b0;
    tick(253);
    chk("b_valid", 32'(bus_b.valid), 32'd1);
    chk("b_busy",  32'(bus_b.busy), 32'd0);
    tick(1);
    chk("b_idle_valid", 32'(bus_b.valid), 32'd0);
    exp_q = {3, 5, 9, 17, 33, 65, 129, 257};
    chk_steps("b_steps", step_qb, mark, exp_q);
    chk("b_valid_count", 32'(valid_qb.size()), 32'd1);
    chk("b_model",   32'(bad_step), 32'd0);
    chk("overlap",   32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
